prio_mux_pipe: RTL and testbench
================================

PRIO_MUX_PIPE -- requirements
Module: prio_mux_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width per input channel.
REQ-002 Parameter N_IN, default 27, number of input channels; legal range 2..256.
REQ-003 Parameter RADIX, default 4, fan-in of each mux-tree stage; legal values 2, 4, 8.
REQ-004 Parameter SEL_W, default 5, select width; SHALL satisfy 2^SEL_W >= N_IN.
REQ-005 Parameter CNT_W, default 16, width of error counter.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 ce  input  1  pipeline clock enable; low freezes all pipeline state.
REQ-009 in_valid  input  1  qualifies sel/din this cycle.
REQ-010 sel  input  SEL_W  channel index, 0..N_IN-1 legal.
REQ-011 din  input  N_IN*WIDTH  flat input bus; channel i at bits [i*WIDTH +: WIDTH].
REQ-012 err_clr  input  1  synchronous clear of err_cnt.
REQ-013 dout  output  WIDTH  selected channel data, registered.
REQ-014 out_valid  output  1  qualifies dout/sel_err.
REQ-015 sel_err  output  1  token carried out-of-range select.
REQ-016 err_cnt  output  CNT_W  saturating count of out-of-range tokens.

Function
REQ-017 Block SHALL implement a registered mux tree of STAGES levels, STAGES = smallest s >= 1 with RADIX^s >= N_IN (defaults: 3).
REQ-018 Stage k SHALL select using sel digit k (log2(RADIX) bits, LSB digit at stage 0); channels beyond N_IN SHALL read as zero.
REQ-019 Remaining sel digits, valid bit and range flag SHALL travel with data through every stage register.
REQ-020 Latency SHALL be exactly STAGES enabled cycles (ce=1) from in_valid sample to out_valid.
REQ-021 Throughput SHALL be one token per enabled cycle; no bubbles inserted.
REQ-022 When ce=0, every pipeline register, dout, out_valid, sel_err and err_cnt SHALL hold; inputs ignored.
REQ-023 Range check (sel >= N_IN) SHALL be evaluated at stage-0 capture; such token SHALL emerge with dout=0, sel_err=1, out_valid=1.
REQ-024 Legal token SHALL emerge with dout=din channel sel as sampled at capture, sel_err=0.
REQ-025 dout and sel_err SHALL update only when a valid token exits; with out_valid=0 they hold last value.
REQ-026 out_valid SHALL be 0 in any enabled cycle with no valid token exiting.
REQ-027 err_cnt SHALL increment by 1 on each exiting token with sel_err=1, saturating at 2^CNT_W-1.
REQ-028 err_clr=1 SHALL zero err_cnt on next edge regardless of ce; simultaneous err_clr and error exit -> err_cnt=0 (clear wins).
REQ-029 Data captured from din SHALL not be affected by later din changes (pipeline snapshots at stage 0).

Reset
REQ-030 rst_n low SHALL immediately clear all pipeline valid bits, dout=0, out_valid=0, sel_err=0, err_cnt=0.
REQ-031 Reset mid-operation SHALL discard all in-flight tokens; none emerge after release.
REQ-032 First token sampled after rst_n rises SHALL appear after STAGES enabled cycles.

Verification
REQ-033 Defaults, ce=1, din channel i = 32'hA000_0000+i, in_valid pulse sel=26 -> 3 cycles later out_valid=1, dout=32'hA000_001A, sel_err=0.
REQ-034 Back-to-back sel=0,1,...,26 every cycle -> 27 consecutive out_valid cycles, dout=32'hA000_0000..32'hA000_001A in order.
REQ-035 sel=27 then sel=31 -> two outputs dout=0, sel_err=1; err_cnt=2; err_clr pulse -> err_cnt=0.
REQ-036 Token sel=5 issued, ce=0 for 4 cycles after 1st stage -> output appears after 3 enabled cycles total, dout=32'hA000_0005, nothing emerges during ce=0.
REQ-037 Two tokens in flight, rst_n low 1 cycle asynchronously -> out_valid=0, dout=0 immediately; no tokens emerge afterwards.
REQ-038 CNT_W=2, five out-of-range tokens -> err_cnt saturates at 3.

Source files
------------

// File: rtl/prio_mux_pipe.sv
// Pipelined wide multiplexer built as a registered RADIX-ary tree.
// Each tree level consumes one select digit (LSB digit first); the digits
// still needed, the valid bit and the out-of-range flag ride along with the
// data. The final level is the output register and only loads on a valid
// token, so dout/sel_err hold between tokens.
module prio_mux_pipe #(
   parameter int WIDTH = 32,
   parameter int N_IN  = 27,
   parameter int RADIX = 4,
   parameter int SEL_W = 5,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ce,
   input  logic                   in_valid,
   input  logic [SEL_W-1:0]       sel,
   input  logic [N_IN*WIDTH-1:0]  din,
   input  logic                   err_clr,
   output logic [WIDTH-1:0]       dout,
   output logic                   out_valid,
   output logic                   sel_err,
   output logic [CNT_W-1:0]       err_cnt
);

   function automatic int ipow(input int b, input int e);
      int r;
      r = 1;
      for (int i = 0; i < e; i++) r = r * b;
      return r;
   endfunction

   function automatic int calc_stages(input int n, input int r);
      int s;
      int p;
      s = 1;
      p = r;
      while (p < n) begin
         p = p * r;
         s = s + 1;
      end
      return s;
   endfunction

   localparam int DW     = $clog2(RADIX);
   localparam int STAGES = calc_stages(N_IN, RADIX);
   localparam int NP     = ipow(RADIX, STAGES);
   localparam int SW     = STAGES * DW;
   localparam logic [SEL_W:0] N_IN_V = (SEL_W + 1)'(N_IN);

   logic [SW-1:0]    sel_pad;
   logic             range_err;
   logic [WIDTH-1:0] din_pad [NP];

   // Select bits beyond the tree depth only matter for the range check.
   if (SEL_W >= SW) begin : g_sel_trunc
      assign sel_pad = sel[SW-1:0];
   end else begin : g_sel_ext
      assign sel_pad = {{(SW - SEL_W){1'b0}}, sel};
   end

   assign range_err = ({1'b0, sel} >= N_IN_V);

   // Channels past N_IN fill the tree with zeros.
   for (genvar i = 0; i < NP; i++) begin : g_pad
      if (i < N_IN) begin : g_real
         assign din_pad[i] = din[i*WIDTH +: WIDTH];
      end else begin : g_zero
         assign din_pad[i] = '0;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int N_OUT = NP / ipow(RADIX, k + 1);
      localparam int RW    = (STAGES - 1 - k) * DW;

      logic [DW-1:0]    d;
      logic             v_in;
      logic             e_in;
      logic             v_q;
      logic             e_q;
      logic [WIDTH-1:0] q [N_OUT];

      if (k == 0) begin : g_src
         assign d    = sel_pad[DW-1:0];
         assign v_in = in_valid;
         assign e_in = range_err;
      end else begin : g_src
         assign d    = g_stage[k-1].g_rem.rem_q[DW-1:0];
         assign v_in = g_stage[k-1].v_q;
         assign e_in = g_stage[k-1].e_q;
      end

      // Digits for the levels still ahead of this one.
      if (k < STAGES - 1) begin : g_rem
         logic [RW-1:0] rem_d;
         logic [RW-1:0] rem_q;
         if (k == 0) begin : g_rsrc
            assign rem_d = sel_pad[SW-1:DW];
         end else begin : g_rsrc
            assign rem_d = g_stage[k-1].g_rem.rem_q[RW+DW-1:DW];
         end

         // Remaining-digit register advances with the token.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  rem_q <= '0;
            else if (ce) rem_q <= rem_d;
         end
      end

      // Token qualifiers; the output level keeps sel_err between tokens.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            e_q <= 1'b0;
         end else if (ce) begin
            v_q <= v_in;
            if (k < STAGES - 1 || v_in) e_q <= e_in;
         end
      end

      for (genvar o = 0; o < N_OUT; o++) begin : g_node
         logic [WIDTH-1:0] grp [RADIX];
         for (genvar r = 0; r < RADIX; r++) begin : g_leg
            if (k == 0) begin : g_from_in
               assign grp[r] = din_pad[o*RADIX + r];
            end else begin : g_from_prev
               assign grp[r] = g_stage[k-1].q[o*RADIX + r];
            end
         end

         if (k < STAGES - 1) begin : g_mid
            // Interior node: pick one leg of its group every enabled cycle.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)  q[o] <= '0;
               else if (ce) q[o] <= grp[d];
            end
         end else begin : g_last
            // Output node: loads only on a valid token, zero for bad selects.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)              q[o] <= '0;
               else if (ce && v_in)     q[o] <= e_in ? '0 : grp[d];
            end
         end
      end
   end

   assign dout      = g_stage[STAGES-1].q[0];
   assign out_valid = g_stage[STAGES-1].v_q;
   assign sel_err   = g_stage[STAGES-1].e_q;

   // Saturating count of bad-select tokens leaving the tree; clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (err_clr) begin
         err_cnt <= '0;
      end else if (ce && g_stage[STAGES-1].v_in && g_stage[STAGES-1].e_in
                   && (err_cnt != {CNT_W{1'b1}})) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_prio_mux_pipe.sv
module tb_prio_mux_pipe;

   localparam int WIDTH = 32;
   localparam int N_IN  = 27;
   localparam int SEL_W = 5;

   logic                  clk;
   logic                  rst_n;
   logic                  ce;
   logic                  in_valid;
   logic [SEL_W-1:0]      sel;
   logic [N_IN*WIDTH-1:0] din;
   logic                  err_clr;
   logic [WIDTH-1:0]      dout;
   logic                  out_valid;
   logic                  sel_err;
   logic [15:0]           err_cnt;
   logic [WIDTH-1:0]      dout2;
   logic                  out_valid2;
   logic                  sel_err2;
   logic [1:0]            err_cnt2;

   int checks;
   int errors;

   prio_mux_pipe dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .sel(sel),
      .din(din), .err_clr(err_clr), .dout(dout), .out_valid(out_valid),
      .sel_err(sel_err), .err_cnt(err_cnt)
   );

   prio_mux_pipe #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .sel(sel),
      .din(din), .err_clr(err_clr), .dout(dout2), .out_valid(out_valid2),
      .sel_err(sel_err2), .err_cnt(err_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; sel = '0; err_clr = 1'b0;
      for (int i = 0; i < N_IN; i++) din[i*WIDTH +: WIDTH] = 32'hA000_0000 + i;
      #1;
      checks++;
      if (dout !== 32'h0 || out_valid !== 1'b0 || sel_err !== 1'b0 || err_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: dout=%h ov=%b se=%b cnt=%0d required 0/0/0/0", dout, out_valid, sel_err, err_cnt);
      end
      checks++;
      if (out_valid2 !== 1'b0 || err_cnt2 !== 2'd0 || dout2 !== 32'h0 || sel_err2 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state_sat: ov=%b cnt=%0d required 0/0", out_valid2, err_cnt2);
      end
      tick();
      tick();
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      in_valid = 1'b1; sel = 5'd26;
      tick();
      in_valid = 1'b0; sel = 5'd3;
      din[26*WIDTH +: WIDTH] = 32'h5555_5555;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_early: out_valid=%b required 0", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || dout !== 32'hA000_001A || sel_err !== 1'b0) begin
         errors++;
         $display("FAIL single_out: ov=%b dout=%h se=%b required 1/a000001a/0", out_valid, dout, sel_err);
      end
      din[26*WIDTH +: WIDTH] = 32'hA000_001A;
      tick();
      checks++;
      if (out_valid !== 1'b0 || dout !== 32'hA000_001A) begin
         errors++;
         $display("FAIL single_hold: ov=%b dout=%h required 0/a000001a", out_valid, dout);
      end
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 29; t++) begin
         if (t < N_IN) begin
            in_valid = 1'b1; sel = SEL_W'(t);
         end else begin
            in_valid = 1'b0; sel = '0;
         end
         tick();
         if (t >= 2) begin
            checks++;
            if (out_valid !== 1'b1 || dout !== 32'hA000_0000 + 32'(t - 2) || sel_err !== 1'b0) begin
               errors++;
               $display("FAIL b2b_%0d: ov=%b dout=%h required 1/%h", t - 2, out_valid, dout, 32'hA000_0000 + 32'(t - 2));
            end
         end
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_range_err();
      in_valid = 1'b1; sel = 5'd27;
      tick();
      sel = 5'd31;
      tick();
      in_valid = 1'b0; sel = '0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || sel_err !== 1'b1 || dout !== 32'h0 || err_cnt !== 16'd1) begin
         errors++;
         $display("FAIL range_first: ov=%b se=%b dout=%h cnt=%0d required 1/1/0/1", out_valid, sel_err, dout, err_cnt);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || sel_err !== 1'b1 || dout !== 32'h0 || err_cnt !== 16'd2) begin
         errors++;
         $display("FAIL range_second: ov=%b se=%b dout=%h cnt=%0d required 1/1/0/2", out_valid, sel_err, dout, err_cnt);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || sel_err !== 1'b1 || err_cnt !== 16'd2) begin
         errors++;
         $display("FAIL range_idle: ov=%b se=%b cnt=%0d required 0/1/2", out_valid, sel_err, err_cnt);
      end
      err_clr = 1'b1; ce = 1'b0;
      tick();
      err_clr = 1'b0; ce = 1'b1;
      checks++;
      if (err_cnt !== 16'd0 || err_cnt2 !== 2'd0) begin
         errors++;
         $display("FAIL range_clear: cnt=%0d cnt_sat=%0d required 0/0", err_cnt, err_cnt2);
      end
   endtask

   task automatic test_ce_hold();
      in_valid = 1'b1; sel = 5'd5;
      tick();
      ce = 1'b0; sel = 5'd3;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ce_frozen_%0d: out_valid=%b required 0", i, out_valid);
         end
      end
      ce = 1'b1; in_valid = 1'b0; sel = '0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ce_second: out_valid=%b required 0", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || dout !== 32'hA000_0005 || sel_err !== 1'b0) begin
         errors++;
         $display("FAIL ce_out: ov=%b dout=%h se=%b required 1/a0000005/0", out_valid, dout, sel_err);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || dout !== 32'hA000_0005) begin
         errors++;
         $display("FAIL ce_ignored: ov=%b dout=%h required 0/a0000005", out_valid, dout);
      end
   endtask

   task automatic test_saturate();
      for (int i = 27; i < 32; i++) begin
         in_valid = 1'b1; sel = SEL_W'(i);
         tick();
      end
      in_valid = 1'b0; sel = '0;
      repeat (3) tick();
      checks++;
      if (err_cnt !== 16'd5) begin
         errors++;
         $display("FAIL sat_wide: err_cnt=%0d required 5", err_cnt);
      end
      checks++;
      if (err_cnt2 !== 2'd3) begin
         errors++;
         $display("FAIL sat_narrow: err_cnt=%0d required 3", err_cnt2);
      end
      in_valid = 1'b1; sel = 5'd30;
      tick();
      in_valid = 1'b0; sel = '0;
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || sel_err !== 1'b1 || err_cnt !== 16'd0 || err_cnt2 !== 2'd0) begin
         errors++;
         $display("FAIL clear_wins: ov=%b se=%b cnt=%0d cnt_sat=%0d required 1/1/0/0", out_valid, sel_err, err_cnt, err_cnt2);
      end
      tick();
   endtask

   task automatic test_reset_midflight();
      in_valid = 1'b1; sel = 5'd28;
      tick();
      sel = 5'd1;
      tick();
      sel = 5'd2;
      tick();
      in_valid = 1'b0; sel = '0;
      checks++;
      if (out_valid !== 1'b1 || sel_err !== 1'b1 || err_cnt !== 16'd1) begin
         errors++;
         $display("FAIL pre_reset: ov=%b se=%b cnt=%0d required 1/1/1", out_valid, sel_err, err_cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || dout !== 32'h0 || sel_err !== 1'b0 || err_cnt !== 16'd0) begin
         errors++;
         $display("FAIL async_reset: ov=%b dout=%h se=%b cnt=%0d required 0/0/0/0", out_valid, dout, sel_err, err_cnt);
      end
      #2 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || dout !== 32'h0) begin
            errors++;
            $display("FAIL flushed_%0d: ov=%b dout=%h required 0/0", i, out_valid, dout);
         end
      end
   endtask

   task automatic test_first_after_reset();
      in_valid = 1'b1; sel = 5'd7;
      tick();
      in_valid = 1'b0; sel = '0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL first_early: out_valid=%b required 0", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || dout !== 32'hA000_0007 || sel_err !== 1'b0) begin
         errors++;
         $display("FAIL first_out: ov=%b dout=%h se=%b required 1/a0000007/0", out_valid, dout, sel_err);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_range_err();
      test_ce_hold();
      test_saturate();
      test_reset_midflight();
      test_first_after_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
